dual_framebuffer_ctrl: RTL and testbench

- Parametrised double-buffered framebuffer controller. It owns a single write port into one memory sized 2*WIDTH*HEIGHT pixels, split into two banks.
- Renderer pixel writes always land in the back bank. Display scan reads are translated to front-bank addresses.
- Bank swaps are deferred until end of frame.
- A built-in clear engine fills the back bank with a constant colour.
- Sits between the video generator, the display scan logic and the framebuffer dpram. Replaces the direct single-bank framebuffer hookup.

---
 rtl/fb_pkg.sv | 28 ++
 rtl/fb_addr_gen.sv | 33 +++
 rtl/dual_framebuffer_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_dual_framebuffer_ctrl.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and helpers for the double-buffered framebuffer controller.
//
// Contents:
//   fb_state_t : controller state encoding
//   pixel_t    : default-width pixel word
//   fb_addr()  : linear pixel address, base + x + width*y
package fb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEARING  = 2'd1,
        SWAP_WAIT = 2'd2
    } fb_state_t;

    localparam int DEFAULT_PIXEL_BITS = 16;

    typedef logic [DEFAULT_PIXEL_BITS-1:0] pixel_t;

    // 32-bit working width is wide enough for any realistic display size;
    // callers cast the result down to their address width.
    function automatic logic [31:0] fb_addr(input logic [31:0] base,
                                            input logic [31:0] x,
                                            input logic [31:0] y,
                                            input logic [31:0] width);
        return base + x + width * y;
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Registered linear address generator: addr <= base + x + WIDTH*y.
//
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset, clears addr
//   base : bank base address
//   x, y : pixel coordinates
//   addr : registered address, one cycle after base/x/y
module fb_addr_gen
    import fb_pkg::*;
#(
    parameter int WIDTH     = 320,
    parameter int XB        = 9,
    parameter int YB        = 8,
    parameter int ADDR_BITS = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] base,
    input  logic [XB-1:0]        x,
    input  logic [YB-1:0]        y,
    output logic [ADDR_BITS-1:0] addr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
        end else begin
            addr <= ADDR_BITS'(fb_addr(32'(base), 32'(x), 32'(y), 32'(WIDTH)));
        end
    end

endmodule

// File: rtl/dual_framebuffer_ctrl.sv
// Double-buffered framebuffer controller. Renderer writes land in the back
// bank, display reads are mapped to the front bank, swaps wait for vblank,
// and a clear engine fills the back bank with a constant colour.
//
// Optional build macro: FB_AUTO_CLEAR_ON_SWAP_EN
//   When defined, every completed swap is followed by a clear of the new
//   back bank using the last latched clear colour.
//
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   pix_wr_en/x/y/data, ready    : renderer write port
//   rd_x, rd_y, rd_addr          : display scan address translation
//   frame_end, swap_req, swap_ack: bank swap handshake
//   clear_req, clear_color       : clear engine request
//   busy, front_sel              : status
//   mem_wr_en/addr/data          : framebuffer memory write port
//
// state     | meaning
// ----------+---------------------------------------------------
// IDLE      | accepting renderer writes and requests
// CLEARING  | one clear write per cycle into the back bank
// SWAP_WAIT | swap requested, waiting for frame_end
module dual_framebuffer_ctrl
    import fb_pkg::*;
#(
    parameter  int WIDTH      = 320,
    parameter  int HEIGHT     = 240,
    parameter  int PIXEL_BITS = 16,
    localparam int PIXELS     = WIDTH * HEIGHT,
    localparam int ADDR_BITS  = $clog2(2 * PIXELS),
    localparam int XB         = $clog2(WIDTH),
    localparam int YB         = $clog2(HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_wr_en,
    output logic                  pix_wr_ready,
    input  logic [XB-1:0]         pix_x,
    input  logic [YB-1:0]         pix_y,
    input  logic [PIXEL_BITS-1:0] pix_wr_data,
    input  logic [XB-1:0]         rd_x,
    input  logic [YB-1:0]         rd_y,
    output logic [ADDR_BITS-1:0]  rd_addr,
    input  logic                  frame_end,
    input  logic                  swap_req,
    output logic                  swap_ack,
    input  logic                  clear_req,
    input  logic [PIXEL_BITS-1:0] clear_color,
    output logic                  busy,
    output logic                  front_sel,
    output logic                  mem_wr_en,
    output logic [ADDR_BITS-1:0]  mem_wr_addr,
    output logic [PIXEL_BITS-1:0] mem_wr_data
);

    localparam logic [ADDR_BITS-1:0] BANK1_BASE = ADDR_BITS'(PIXELS);
    localparam logic [ADDR_BITS-1:0] LAST_PIX   = ADDR_BITS'(PIXELS - 1);

    fb_state_t             state;
    logic                  swap_pend;
    logic [ADDR_BITS-1:0]  counter;
    logic [PIXEL_BITS-1:0] clr_color;

    logic [ADDR_BITS-1:0]  front_base;
    logic [ADDR_BITS-1:0]  back_base;
    logic [ADDR_BITS-1:0]  wr_base;
    logic [XB-1:0]         wr_x;
    logic [YB-1:0]         wr_y;
    logic                  pix_in_range;

    assign front_base = front_sel ? BANK1_BASE : '0;
    assign back_base  = front_sel ? '0 : BANK1_BASE;

    // The write address generator is shared: during a clear the counter is
    // folded into the base and the coordinates are forced to zero.
    assign wr_base = (state == CLEARING) ? (back_base + counter) : back_base;
    assign wr_x    = (state == CLEARING) ? '0 : pix_x;
    assign wr_y    = (state == CLEARING) ? '0 : pix_y;

    assign pix_in_range = (32'(pix_x) < WIDTH) && (32'(pix_y) < HEIGHT);

    fb_addr_gen #(
        .WIDTH     (WIDTH),
        .XB        (XB),
        .YB        (YB),
        .ADDR_BITS (ADDR_BITS)
    ) u_rd_addr_gen (
        .clk  (clk),
        .rst  (rst),
        .base (front_base),
        .x    (rd_x),
        .y    (rd_y),
        .addr (rd_addr)
    );

    fb_addr_gen #(
        .WIDTH     (WIDTH),
        .XB        (XB),
        .YB        (YB),
        .ADDR_BITS (ADDR_BITS)
    ) u_wr_addr_gen (
        .clk  (clk),
        .rst  (rst),
        .base (wr_base),
        .x    (wr_x),
        .y    (wr_y),
        .addr (mem_wr_addr)
    );

    // pix_wr_ready and busy are written alongside every state change so
    // they always describe the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            front_sel    <= 1'b0;
            swap_pend    <= 1'b0;
            counter      <= '0;
            clr_color    <= '0;
            pix_wr_ready <= 1'b0;
            busy         <= 1'b0;
            swap_ack     <= 1'b0;
            mem_wr_en    <= 1'b0;
            mem_wr_data  <= '0;
        end else begin
            swap_ack  <= 1'b0;
            mem_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (pix_wr_ready && pix_wr_en && pix_in_range) begin
                        mem_wr_en   <= 1'b1;
                        mem_wr_data <= pix_wr_data;
                    end
                    if (clear_req) begin
                        state        <= CLEARING;
                        clr_color    <= clear_color;
                        counter      <= '0;
                        swap_pend    <= swap_req;
                        pix_wr_ready <= 1'b0;
                        busy         <= 1'b1;
                    end else if (swap_req) begin
                        state        <= SWAP_WAIT;
                        pix_wr_ready <= 1'b0;
                        busy         <= 1'b1;
                    end else begin
                        pix_wr_ready <= 1'b1;
                        busy         <= 1'b0;
                    end
                end
                CLEARING: begin
                    mem_wr_en   <= 1'b1;
                    mem_wr_data <= clr_color;
                    counter     <= counter + ADDR_BITS'(1);
                    if (counter == LAST_PIX) begin
                        if (swap_pend) begin
                            swap_pend <= 1'b0;
                            state     <= SWAP_WAIT;
                        end else begin
                            state        <= IDLE;
                            pix_wr_ready <= 1'b1;
                            busy         <= 1'b0;
                        end
                    end
                end
                SWAP_WAIT: begin
                    if (frame_end) begin
                        front_sel <= ~front_sel;
                        swap_ack  <= 1'b1;
`ifdef FB_AUTO_CLEAR_ON_SWAP_EN
                        state     <= CLEARING;
                        counter   <= '0;
`else
                        state        <= IDLE;
                        pix_wr_ready <= 1'b1;
                        busy         <= 1'b0;
`endif
                    end
                end
                default: begin
                    state        <= IDLE;
                    pix_wr_ready <= 1'b1;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dual_framebuffer_ctrl.sv
module tb_dual_framebuffer_ctrl;

    localparam int W   = 20;
    localparam int H   = 12;
    localparam int PB  = 16;
    localparam int PIX = W * H;
    localparam int AB  = $clog2(2 * PIX);
    localparam int XB  = $clog2(W);
    localparam int YB  = $clog2(H);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pix_wr_en = 1'b0;
    logic          pix_wr_ready;
    logic [XB-1:0] pix_x = '0;
    logic [YB-1:0] pix_y = '0;
    logic [PB-1:0] pix_wr_data = '0;
    logic [XB-1:0] rd_x = '0;
    logic [YB-1:0] rd_y = '0;
    logic [AB-1:0] rd_addr;
    logic          frame_end = 1'b0;
    logic          swap_req = 1'b0;
    logic          swap_ack;
    logic          clear_req = 1'b0;
    logic [PB-1:0] clear_color = '0;
    logic          busy;
    logic          front_sel;
    logic          mem_wr_en;
    logic [AB-1:0] mem_wr_addr;
    logic [PB-1:0] mem_wr_data;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    bit m_front = 1'b0;
    logic [PB-1:0] last_color = '0;
    logic [PB-1:0] mem_ref [0:(1<<AB)-1] = '{default: '0};
    logic [PB-1:0] mem_dut [0:(1<<AB)-1] = '{default: '0};

    dual_framebuffer_ctrl #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .PIXEL_BITS (PB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pix_wr_en    (pix_wr_en),
        .pix_wr_ready (pix_wr_ready),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .pix_wr_data  (pix_wr_data),
        .rd_x         (rd_x),
        .rd_y         (rd_y),
        .rd_addr      (rd_addr),
        .frame_end    (frame_end),
        .swap_req     (swap_req),
        .swap_ack     (swap_ack),
        .clear_req    (clear_req),
        .clear_color  (clear_color),
        .busy         (busy),
        .front_sel    (front_sel),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data)
    );

    always #5 clk = ~clk;

    // Memory image as seen by the framebuffer RAM.
    always @(posedge clk) begin
        if (mem_wr_en === 1'b1) begin
            mem_dut[mem_wr_addr] = mem_wr_data;
            wr_cnt = wr_cnt + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int lin(int base, int x, int y);
        return base + x + W * y;
    endfunction

    function automatic int front_base();
        return m_front ? PIX : 0;
    endfunction

    function automatic int back_base();
        return m_front ? 0 : PIX;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pix_wr_en = 1'b0;
        clear_req = 1'b0;
        swap_req  = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic fill_back(input logic [PB-1:0] c, input int count);
        int bb = back_base();
        for (int i = 0; i < count; i++) mem_ref[bb + i] = c;
    endtask

    // Expects the DUT to be in its first clear cycle; waits for busy to drop
    // while throwing ignored requests at it.
    task automatic wait_clear(input logic [PB-1:0] c, input int exp_n);
        int n = 0;
        int w0 = wr_cnt;
        while (busy === 1'b1 && n < 2 * PIX) begin
            pix_wr_en = 1'($urandom);
            pix_x     = XB'($urandom_range(0, W - 1));
            pix_y     = YB'($urandom_range(0, H - 1));
            clear_req = 1'($urandom);
            swap_req  = 1'($urandom);
            frame_end = 1'($urandom);
            step();
            n++;
        end
        idle_inputs();
        step();
        checks++;
        if (n != exp_n) begin
            failures++;
            $display("FAIL clear_cycles: busy cycles %0d, required %0d", n, exp_n);
        end
        checks++;
        if (wr_cnt - w0 != PIX) begin
            failures++;
            $display("FAIL clear_writes: got %0d writes, required %0d", wr_cnt - w0, PIX);
        end
        checks++;
        if (pix_wr_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL clear_done: ready=%b busy=%b, required ready=1 busy=0", pix_wr_ready, busy);
        end
        fill_back(c, PIX);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pix_wr_en = 1'b1; clear_req = 1'b1; swap_req = 1'b1; frame_end = 1'b1;
        rd_x = XB'($urandom_range(1, W - 1)); rd_y = YB'($urandom_range(1, H - 1));
        pix_wr_data = PB'($urandom);
        step(); step();
        checks++;
        if ({pix_wr_ready, busy, swap_ack, mem_wr_en, front_sel, mem_wr_addr, mem_wr_data, rd_addr} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b busy=%b ack=%b en=%b front=%b waddr=%0d wdata=%h rd=%0d, required all 0",
                     pix_wr_ready, busy, swap_ack, mem_wr_en, front_sel, mem_wr_addr, mem_wr_data, rd_addr);
        end
        idle_inputs();
        rst = 1'b0;
        m_front = 1'b0;
        last_color = '0;
        step();
        checks++;
        if (pix_wr_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: ready=%b busy=%b, required ready=1 busy=0", pix_wr_ready, busy);
        end
    endtask

    task automatic test_write_basic();
        pix_wr_en = 1'b1; pix_x = 3; pix_y = 2; pix_wr_data = 16'hABCD;
        step();
        pix_wr_en = 1'b0;
        checks++;
        if (mem_wr_en !== 1'b1 || mem_wr_addr !== AB'(lin(PIX, 3, 2)) || mem_wr_data !== 16'hABCD) begin
            failures++;
            $display("FAIL write_basic: en=%b addr=%0d data=%h, required en=1 addr=%0d data=abcd",
                     mem_wr_en, mem_wr_addr, mem_wr_data, lin(PIX, 3, 2));
        end
        mem_ref[lin(PIX, 3, 2)] = 16'hABCD;
        step();
        checks++;
        if (mem_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL write_one_shot: en=%b, required 0", mem_wr_en);
        end
    endtask

    task automatic test_random_rw(input int n);
        for (int i = 0; i < n; i++) begin
            int x = $urandom_range(0, W + 3);
            int y = $urandom_range(0, H + 2);
            int rx = $urandom_range(0, W - 1);
            int ry = $urandom_range(0, H - 1);
            bit en = 1'($urandom);
            logic [PB-1:0] d = PB'($urandom);
            bit exp_wr = en && x < W && y < H;
            pix_wr_en = en; pix_x = XB'(x); pix_y = YB'(y); pix_wr_data = d;
            rd_x = XB'(rx); rd_y = YB'(ry);
            step();
            checks++;
            if (rd_addr !== AB'(lin(front_base(), rx, ry))) begin
                failures++;
                $display("FAIL rand_rd_addr: got %0d, required %0d", rd_addr, lin(front_base(), rx, ry));
            end
            checks++;
            if (exp_wr) begin
                if (mem_wr_en !== 1'b1 || mem_wr_addr !== AB'(lin(back_base(), x, y)) || mem_wr_data !== d) begin
                    failures++;
                    $display("FAIL rand_write: en=%b addr=%0d data=%h, required en=1 addr=%0d data=%h",
                             mem_wr_en, mem_wr_addr, mem_wr_data, lin(back_base(), x, y), d);
                end
                mem_ref[lin(back_base(), x, y)] = d;
            end else if (mem_wr_en !== 1'b0) begin
                failures++;
                $display("FAIL rand_nowrite: en=%b for x=%0d y=%0d en_in=%b, required 0", mem_wr_en, x, y, en);
            end
        end
        pix_wr_en = 1'b0;
    endtask

    task automatic test_clear();
        logic [PB-1:0] c = PB'($urandom);
        clear_color = c; clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        last_color = c;
        checks++;
        if (busy !== 1'b1 || pix_wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL clear_start: busy=%b ready=%b, required busy=1 ready=0", busy, pix_wr_ready);
        end
        wait_clear(c, PIX);
    endtask

    task automatic finish_swap();
        frame_end = 1'b1; rd_x = 0; rd_y = 0;
        step();
        frame_end = 1'b0;
        checks++;
        if (swap_ack !== 1'b1 || front_sel !== ~m_front || rd_addr !== AB'(front_base())) begin
            failures++;
            $display("FAIL swap_ack: ack=%b front=%b rd=%0d, required ack=1 front=%b rd=%0d",
                     swap_ack, front_sel, rd_addr, ~m_front, front_base());
        end
        m_front = ~m_front;
        step();
        checks++;
        if (swap_ack !== 1'b0 || rd_addr !== AB'(front_base())) begin
            failures++;
            $display("FAIL swap_after: ack=%b rd=%0d, required ack=0 rd=%0d", swap_ack, rd_addr, front_base());
        end
`ifdef FB_AUTO_CLEAR_ON_SWAP_EN
        wait_clear(last_color, PIX - 1);
`else
        checks++;
        if (busy !== 1'b0 || pix_wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL swap_idle: busy=%b ready=%b, required busy=0 ready=1", busy, pix_wr_ready);
        end
`endif
    endtask

    task automatic test_swap();
        logic [PB-1:0] d = PB'($urandom);
        int wait_n = $urandom_range(5, 12);
        bit bad = 1'b0;
        swap_req = 1'b1; frame_end = 1'b1;
        step();
        idle_inputs();
        for (int i = 0; i < wait_n; i++) begin
            clear_req = 1'($urandom);
            swap_req  = 1'($urandom);
            step();
            if (swap_ack !== 1'b0 || busy !== 1'b1) bad = 1'b1;
        end
        idle_inputs();
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL swap_wait: ack or busy wrong while waiting, ack=%b busy=%b required ack=0 busy=1", swap_ack, busy);
        end
        finish_swap();
        pix_wr_en = 1'b1; pix_x = 0; pix_y = 0; pix_wr_data = d;
        step();
        pix_wr_en = 1'b0;
        checks++;
        if (mem_wr_en !== 1'b1 || mem_wr_addr !== AB'(back_base()) || mem_wr_data !== d) begin
            failures++;
            $display("FAIL swap_back_write: en=%b addr=%0d data=%h, required en=1 addr=%0d data=%h",
                     mem_wr_en, mem_wr_addr, mem_wr_data, back_base(), d);
        end
        mem_ref[back_base()] = d;
        step();
    endtask

    task automatic test_reset_mid_clear();
        logic [PB-1:0] c = PB'($urandom);
        int w0;
        clear_color = c; clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        w0 = wr_cnt;
        repeat (5) step();
        rst = 1'b1;
        step();
        checks++;
        if ({pix_wr_ready, busy, swap_ack, mem_wr_en, front_sel, mem_wr_addr, mem_wr_data, rd_addr} !== '0) begin
            failures++;
            $display("FAIL midclear_reset: ready=%b busy=%b ack=%b en=%b front=%b waddr=%0d wdata=%h rd=%0d, required all 0",
                     pix_wr_ready, busy, swap_ack, mem_wr_en, front_sel, mem_wr_addr, mem_wr_data, rd_addr);
        end
        checks++;
        if (wr_cnt - w0 != 5) begin
            failures++;
            $display("FAIL midclear_writes: got %0d, required 5", wr_cnt - w0);
        end
        fill_back(c, 5);
        rst = 1'b0;
        m_front = 1'b0;
        last_color = '0;
        step();
        checks++;
        if (pix_wr_ready !== 1'b1 || busy !== 1'b0 || swap_ack !== 1'b0) begin
            failures++;
            $display("FAIL midclear_release: ready=%b busy=%b ack=%b, required 1 0 0", pix_wr_ready, busy, swap_ack);
        end
    endtask

    task automatic test_out_of_range();
        int xs [4] = '{W, 0, W + 3, W - 1};
        int ys [4] = '{5, H, H + 2, H - 1};
        for (int i = 0; i < 4; i++) begin
            logic [PB-1:0] d = PB'($urandom);
            bit inr = xs[i] < W && ys[i] < H;
            pix_wr_en = 1'b1; pix_x = XB'(xs[i]); pix_y = YB'(ys[i]); pix_wr_data = d;
            step();
            pix_wr_en = 1'b0;
            checks++;
            if (mem_wr_en !== inr || (inr && mem_wr_addr !== AB'(lin(back_base(), xs[i], ys[i])))) begin
                failures++;
                $display("FAIL range_edge: x=%0d y=%0d en=%b addr=%0d, required en=%b addr=%0d",
                         xs[i], ys[i], mem_wr_en, mem_wr_addr, inr, lin(back_base(), xs[i], ys[i]));
            end
            if (inr) mem_ref[lin(back_base(), xs[i], ys[i])] = d;
        end
        step();
    endtask

    task automatic test_clear_swap();
        logic [PB-1:0] c = PB'($urandom);
        int w0;
        int acks = 0;
        bit bad = 1'b0;
        clear_color = c; clear_req = 1'b1; swap_req = 1'b1;
        step();
        idle_inputs();
        last_color = c;
        w0 = wr_cnt;
        for (int k = 0; k < PIX + 3; k++) begin
            frame_end = (k == PIX / 2);
            step();
            if (swap_ack === 1'b1) acks++;
            if (busy !== 1'b1) bad = 1'b1;
        end
        frame_end = 1'b0;
        checks++;
        if (acks != 0 || bad) begin
            failures++;
            $display("FAIL clrswap_early: acks=%0d busy_dropped=%b, required acks=0 busy_dropped=0", acks, bad);
        end
        checks++;
        if (wr_cnt - w0 != PIX) begin
            failures++;
            $display("FAIL clrswap_writes: got %0d, required %0d", wr_cnt - w0, PIX);
        end
        fill_back(c, PIX);
        finish_swap();
        acks = 0;
        repeat (4) begin
            step();
            if (swap_ack === 1'b1) acks++;
        end
        checks++;
        if (acks != 0) begin
            failures++;
            $display("FAIL clrswap_extra_ack: got %0d extra acks, required 0", acks);
        end
    endtask

    task automatic test_mem_image();
        int bad = 0;
        int first = -1;
        repeat (2) step();
        for (int a = 0; a < 2 * PIX; a++) begin
            if (mem_dut[a] !== mem_ref[a]) begin
                bad++;
                if (first < 0) first = a;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL mem_image: %0d words differ, first at %0d got %h required %h",
                     bad, first, mem_dut[first], mem_ref[first]);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_random_rw(150);
        test_clear();
        test_swap();
        test_random_rw(100);
        test_reset_mid_clear();
        test_out_of_range();
        test_clear_swap();
        test_random_rw(100);
        test_mem_image();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
